// File: rtl/control_pkg.sv
// rv32i_types: shared RV32I decode types for the multicycle control unit.
//   rv32i_opcode  - 7-bit major opcode encodings
//   alu_ops       - ALU operation codes (aligned with arith funct3 where possible)
//   *_funct3      - funct3 sub-decodes for branch, load, store and arithmetic ops
//   *_sel_t       - datapath mux selects; index 0 is each mux's idle/default input
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3;

  typedef enum logic [2:0] {
    add  = 3'b000,
    sll  = 3'b001,
    slt  = 3'b010,
    sltu = 3'b011,
    axor = 3'b100,
    sr   = 3'b101,
    aor  = 3'b110,
    aand = 3'b111
  } arith_funct3;

  typedef enum logic [1:0] {
    pcmux_pc_plus4 = 2'd0,
    pcmux_alu_out  = 2'd1,
    pcmux_alu_mod2 = 2'd2
  } pcmux_sel_t;

  typedef enum logic {
    marmux_pc_out  = 1'b0,
    marmux_alu_out = 1'b1
  } marmux_sel_t;

  typedef enum logic {
    alumux1_rs1_out = 1'b0,
    alumux1_pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    alumux2_i_imm   = 3'd0,
    alumux2_u_imm   = 3'd1,
    alumux2_b_imm   = 3'd2,
    alumux2_s_imm   = 3'd3,
    alumux2_j_imm   = 3'd4,
    alumux2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    regfilemux_alu_out  = 4'd0,
    regfilemux_br_en    = 4'd1,
    regfilemux_u_imm    = 4'd2,
    regfilemux_lw       = 4'd3,
    regfilemux_pc_plus4 = 4'd4,
    regfilemux_lb       = 4'd5,
    regfilemux_lbu      = 4'd6,
    regfilemux_lh       = 4'd7,
    regfilemux_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic {
    cmpmux_rs2_out = 1'b0,
    cmpmux_i_imm   = 1'b1
  } cmpmux_sel_t;

endpackage

// File: rtl/control_if.sv
// control_if: memory request/response handshake between control and memory.
//   mem_read / mem_write  - request strobes, held until mem_resp
//   mem_byte_enable       - write byte lanes
//   mem_resp              - one-cycle completion pulse from memory
interface control_if;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_byte_enable;
  logic       mem_resp;

  modport master (output mem_read, output mem_write, output mem_byte_enable,
                  input mem_resp);
  modport slave  (input mem_read, input mem_write, input mem_byte_enable,
                  output mem_resp);
endinterface

// File: rtl/control_mem_mask_gen.sv
// mem_mask_gen: byte-lane masks for loads/stores.
//   funct3        - load/store width; bits [1:0] select byte/half/word
//   mem_addr_bits - byte offset of the access within the word
//   rmask / wmask - active byte lanes (same lanes; rmask for loads, wmask for stores)
module mem_mask_gen (
  input  logic [2:0] funct3,
  input  logic [1:0] mem_addr_bits,
  output logic [3:0] rmask,
  output logic [3:0] wmask
);

  logic [3:0] lanes;
  // Bit 2 only distinguishes signed/unsigned loads; lanes don't depend on it.
  logic       unused_sign_bit;
  assign unused_sign_bit = funct3[2];

  always_comb begin
    lanes = 4'b0000;
    case (funct3[1:0])
      2'b00:   lanes = 4'b0001 << mem_addr_bits;
      // Halfwords are assumed aligned, so the low offset bit is dropped.
      2'b01:   lanes = 4'b0011 << {mem_addr_bits[1], 1'b0};
      2'b10:   lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  assign rmask = lanes;
  assign wmask = lanes;

endmodule

// File: rtl/control.sv
// control: multicycle RV32I control FSM.
//   clk, rst         - clock and synchronous active-low reset
//   opcode/funct3/7  - instruction fields from IR
//   br_en            - comparator result from datapath
//   mem_addr_bits    - latched MAR byte offset
//   mem              - memory handshake (control_if master)
//   aluop, load_*    - ALU op and datapath register enables
//   *mux_sel         - datapath mux selects
//   rmask / wmask    - load/store byte masks to datapath
module control
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  rv32i_opcode     opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            br_en,
  input  logic [1:0]      mem_addr_bits,
  control_if.master       mem,
  output alu_ops          aluop,
  output logic            load_ir,
  output logic            load_mar,
  output logic            load_pc,
  output logic            load_regfile,
  output logic            load_mdr,
  output logic            load_data_out,
  output pcmux_sel_t      pcmux_sel,
  output marmux_sel_t     marmux_sel,
  output alumux1_sel_t    alumux1_sel,
  output alumux2_sel_t    alumux2_sel,
  output regfilemux_sel_t regfilemux_sel,
  output cmpmux_sel_t     cmpmux_sel,
  output logic [3:0]      rmask,
  output logic [3:0]      wmask
);

  localparam logic [3:0] S_FETCH1    = 4'd0;
  localparam logic [3:0] S_FETCH2    = 4'd1;
  localparam logic [3:0] S_FETCH3    = 4'd2;
  localparam logic [3:0] S_DECODE    = 4'd3;
  localparam logic [3:0] S_IMM       = 4'd4;
  localparam logic [3:0] S_REG       = 4'd5;
  localparam logic [3:0] S_LUI       = 4'd6;
  localparam logic [3:0] S_AUIPC     = 4'd7;
  localparam logic [3:0] S_BR        = 4'd8;
  localparam logic [3:0] S_CALC_ADDR = 4'd9;
  localparam logic [3:0] S_LD1       = 4'd10;
  localparam logic [3:0] S_LD2       = 4'd11;
  localparam logic [3:0] S_ST1       = 4'd12;
  localparam logic [3:0] S_JAL       = 4'd13;
  localparam logic [3:0] S_JALR      = 4'd14;

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] gen_rmask;
  logic [3:0] gen_wmask;

  // Only funct7[5] (sub/sra) matters to this decoder.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  mem_mask_gen u_mask_gen (
    .funct3        (funct3),
    .mem_addr_bits (mem_addr_bits),
    .rmask         (gen_rmask),
    .wmask         (gen_wmask)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH1;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH1: next_state = S_FETCH2;
      S_FETCH2: if (mem.mem_resp) next_state = S_FETCH3;
      S_FETCH3: next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          op_imm:   next_state = S_IMM;
          op_reg:   next_state = S_REG;
          op_lui:   next_state = S_LUI;
          op_auipc: next_state = S_AUIPC;
          op_br:    next_state = S_BR;
          op_load:  next_state = S_CALC_ADDR;
          op_store: next_state = S_CALC_ADDR;
          op_jal:   next_state = S_JAL;
          op_jalr:  next_state = S_JALR;
          default:  next_state = S_FETCH1;
        endcase
      end
      S_CALC_ADDR: next_state = (opcode == op_store) ? S_ST1 : S_LD1;
      S_LD1:       if (mem.mem_resp) next_state = S_LD2;
      S_ST1:       if (mem.mem_resp) next_state = S_FETCH1;
      default:     next_state = S_FETCH1;
    endcase
  end

  // NOTE: every output gets its default before the case, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    aluop               = alu_add;
    load_ir             = 1'b0;
    load_mar            = 1'b0;
    load_pc             = 1'b0;
    load_regfile        = 1'b0;
    load_mdr            = 1'b0;
    load_data_out       = 1'b0;
    pcmux_sel           = pcmux_pc_plus4;
    marmux_sel          = marmux_pc_out;
    alumux1_sel         = alumux1_rs1_out;
    alumux2_sel         = alumux2_i_imm;
    regfilemux_sel      = regfilemux_alu_out;
    cmpmux_sel          = cmpmux_rs2_out;
    mem.mem_read        = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_byte_enable = 4'b0000;
    rmask               = 4'b0000;
    wmask               = 4'b0000;

    // Outputs stay idle while reset is asserted, whatever the state register holds.
    if (rst) begin
      case (state)
        S_FETCH1: begin
          marmux_sel = marmux_pc_out;
          load_mar   = 1'b1;
        end
        S_FETCH2: begin
          mem.mem_read = 1'b1;
          load_mdr     = 1'b1;
        end
        S_FETCH3: load_ir = 1'b1;
        S_IMM: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          alumux1_sel  = alumux1_rs1_out;
          alumux2_sel  = alumux2_i_imm;
          aluop        = alu_ops'(funct3);
          case (arith_funct3'(funct3))
            slt, sltu: begin
              cmpmux_sel     = cmpmux_i_imm;
              regfilemux_sel = regfilemux_br_en;
            end
            sr:      aluop = funct7[5] ? alu_sra : alu_srl;
            default: ;
          endcase
        end
        S_REG: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          alumux1_sel  = alumux1_rs1_out;
          alumux2_sel  = alumux2_rs2_out;
          cmpmux_sel   = cmpmux_rs2_out;
          aluop        = alu_ops'(funct3);
          case (arith_funct3'(funct3))
            add:       if (funct7[5]) aluop = alu_sub;
            slt, sltu: regfilemux_sel = regfilemux_br_en;
            sr:        aluop = funct7[5] ? alu_sra : alu_srl;
            default:   ;
          endcase
        end
        S_LUI: begin
          regfilemux_sel = regfilemux_u_imm;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
        end
        S_AUIPC: begin
          alumux1_sel    = alumux1_pc_out;
          alumux2_sel    = alumux2_u_imm;
          aluop          = alu_add;
          regfilemux_sel = regfilemux_alu_out;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
        end
        S_BR: begin
          alumux1_sel = alumux1_pc_out;
          alumux2_sel = alumux2_b_imm;
          aluop       = alu_add;
          load_pc     = 1'b1;
          pcmux_sel   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
        end
        S_CALC_ADDR: begin
          alumux1_sel = alumux1_rs1_out;
          aluop       = alu_add;
          marmux_sel  = marmux_alu_out;
          load_mar    = 1'b1;
          if (opcode == op_store) begin
            alumux2_sel   = alumux2_s_imm;
            load_data_out = 1'b1;
          end else begin
            alumux2_sel   = alumux2_i_imm;
          end
        end
        S_LD1: begin
          mem.mem_read = 1'b1;
          load_mdr     = 1'b1;
          rmask        = gen_rmask;
        end
        S_LD2: begin
          rmask        = gen_rmask;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          case (load_funct3'(funct3))
            lb:      regfilemux_sel = regfilemux_lb;
            lh:      regfilemux_sel = regfilemux_lh;
            lbu:     regfilemux_sel = regfilemux_lbu;
            lhu:     regfilemux_sel = regfilemux_lhu;
            default: regfilemux_sel = regfilemux_lw;
          endcase
        end
        S_ST1: begin
          mem.mem_write       = 1'b1;
          wmask               = gen_wmask;
          mem.mem_byte_enable = gen_wmask;
          // PC advances on the completing cycle so fetch1 sees the next address.
          load_pc             = mem.mem_resp;
        end
        S_JAL: begin
          alumux1_sel    = alumux1_pc_out;
          alumux2_sel    = alumux2_j_imm;
          pcmux_sel      = pcmux_alu_out;
          regfilemux_sel = regfilemux_pc_plus4;
          load_pc        = 1'b1;
          load_regfile   = 1'b1;
        end
        S_JALR: begin
          alumux1_sel    = alumux1_rs1_out;
          alumux2_sel    = alumux2_i_imm;
          pcmux_sel      = pcmux_alu_mod2;
          regfilemux_sel = regfilemux_pc_plus4;
          load_pc        = 1'b1;
          load_regfile   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// tb_control: directed-vector bench for the multicycle control FSM.
module tb_control;
  import rv32i_types::*;

  logic            clk;
  logic            rst;
  rv32i_opcode     opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            br_en;
  logic [1:0]      mem_addr_bits;
  alu_ops          aluop;
  logic            load_ir, load_mar, load_pc, load_regfile, load_mdr, load_data_out;
  pcmux_sel_t      pcmux_sel;
  marmux_sel_t     marmux_sel;
  alumux1_sel_t    alumux1_sel;
  alumux2_sel_t    alumux2_sel;
  regfilemux_sel_t regfilemux_sel;
  cmpmux_sel_t     cmpmux_sel;
  logic [3:0]      rmask, wmask;

  int tests = 0;
  int fails = 0;

  control_if bus ();

  control dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .br_en          (br_en),
    .mem_addr_bits  (mem_addr_bits),
    .mem            (bus),
    .aluop          (aluop),
    .load_ir        (load_ir),
    .load_mar       (load_mar),
    .load_pc        (load_pc),
    .load_regfile   (load_regfile),
    .load_mdr       (load_mdr),
    .load_data_out  (load_data_out),
    .pcmux_sel      (pcmux_sel),
    .marmux_sel     (marmux_sel),
    .alumux1_sel    (alumux1_sel),
    .alumux2_sel    (alumux2_sel),
    .regfilemux_sel (regfilemux_sel),
    .cmpmux_sel     (cmpmux_sel),
    .rmask          (rmask),
    .wmask          (wmask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and let combinational outputs settle.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // From fetch1, run a fetch with mem_resp on the first fetch2 cycle; ends in decode.
  task automatic do_fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = rv32i_opcode'(op);
    funct3 = f3;
    funct7 = f7;
    next_cycle();
    bus.mem_resp = 1'b1;
    #1;
    next_cycle();
    bus.mem_resp = 1'b0;
    #1;
    next_cycle();
  endtask

  function automatic logic [5:0] enables();
    return {load_ir, load_mar, load_pc, load_regfile, load_mdr, load_data_out};
  endfunction

  initial begin
    rst           = 1'b0;
    opcode        = op_imm;
    funct3        = 3'd0;
    funct7        = 7'd0;
    br_en         = 1'b0;
    mem_addr_bits = 2'b00;
    bus.mem_resp  = 1'b0;

    // Reset: all outputs at defaults.
    next_cycle();
    next_cycle();
    check("rst_enables", enables(), 6'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_aluop", aluop, alu_add);
    check("rst_masks", {rmask, wmask}, 8'h00);

    // addi x1,x0,5 with mem_resp on the 3rd fetch2 cycle.
    rst = 1'b1;
    opcode = op_imm; funct3 = 3'd0; funct7 = 7'd0;
    #1;
    check("f1_load_mar", load_mar, 1'b1);
    check("f1_marmux", marmux_sel, marmux_pc_out);
    next_cycle();
    check("f2a_mem_read", {bus.mem_read, load_mdr}, 2'b11);
    next_cycle();
    check("f2b_mem_read", bus.mem_read, 1'b1);
    next_cycle();
    bus.mem_resp = 1'b1;
    #1;
    check("f2c_mem_read", bus.mem_read, 1'b1);
    check("f2c_load_ir", load_ir, 1'b0);
    next_cycle();
    bus.mem_resp = 1'b0;
    #1;
    check("f3_load_ir", load_ir, 1'b1);
    check("f3_mem_read", bus.mem_read, 1'b0);
    next_cycle();
    check("decode_enables", enables(), 6'b0);
    next_cycle();
    check("addi_aluop", aluop, alu_add);
    check("addi_load_regfile", load_regfile, 1'b1);
    check("addi_load_pc", load_pc, 1'b1);
    check("addi_alumux2", alumux2_sel, alumux2_i_imm);
    next_cycle();
    check("addi_back_fetch1", load_mar, 1'b1);

    // beq taken.
    do_fetch(op_br, 3'b000, 7'd0);
    br_en = 1'b1;
    next_cycle();
    check("beq_t_pcmux", pcmux_sel, pcmux_alu_out);
    check("beq_t_alumux2", alumux2_sel, alumux2_b_imm);
    check("beq_t_alumux1", alumux1_sel, alumux1_pc_out);
    check("beq_t_load_pc", load_pc, 1'b1);
    next_cycle();

    // beq not taken.
    do_fetch(op_br, 3'b000, 7'd0);
    br_en = 1'b0;
    next_cycle();
    check("beq_nt_pcmux", pcmux_sel, pcmux_pc_plus4);
    next_cycle();

    // sb at offset 2.
    do_fetch(op_store, 3'b000, 7'd0);
    mem_addr_bits = 2'b10;
    next_cycle();
    check("sb_calc_alumux2", alumux2_sel, alumux2_s_imm);
    check("sb_calc_enables", enables(), 6'b010001);
    check("sb_calc_marmux", marmux_sel, marmux_alu_out);
    next_cycle();
    check("sb_st1_wmask", wmask, 4'b0100);
    check("sb_st1_mbe", bus.mem_byte_enable, 4'b0100);
    check("sb_st1_write_pc", {bus.mem_write, load_pc}, 2'b10);
    next_cycle();
    check("sb_st1_hold", bus.mem_write, 1'b1);
    bus.mem_resp = 1'b1;
    #1;
    check("sb_st1_resp", {bus.mem_write, load_pc}, 2'b11);
    next_cycle();
    bus.mem_resp = 1'b0;
    #1;
    check("sb_after_write", bus.mem_write, 1'b0);
    check("sb_after_fetch1", load_mar, 1'b1);

    // sh at offset 2.
    do_fetch(op_store, 3'b001, 7'd0);
    next_cycle();
    next_cycle();
    check("sh_st1_wmask", {wmask, bus.mem_byte_enable}, 8'hCC);
    bus.mem_resp = 1'b1;
    #1;
    next_cycle();
    bus.mem_resp = 1'b0;
    #1;

    // lbu at offset 3.
    do_fetch(op_load, 3'b100, 7'd0);
    mem_addr_bits = 2'b11;
    next_cycle();
    check("lbu_calc_alumux2", alumux2_sel, alumux2_i_imm);
    check("lbu_calc_data_out", load_data_out, 1'b0);
    next_cycle();
    check("lbu_ld1_rmask", rmask, 4'b1000);
    check("lbu_ld1_read", {bus.mem_read, load_mdr}, 2'b11);
    bus.mem_resp = 1'b1;
    #1;
    next_cycle();
    bus.mem_resp = 1'b0;
    #1;
    check("lbu_ld2_rmask", rmask, 4'b1000);
    check("lbu_ld2_regfilemux", regfilemux_sel, regfilemux_lbu);
    check("lbu_ld2_load", {load_regfile, load_pc}, 2'b11);
    next_cycle();
    check("lbu_fetch1", load_mar, 1'b1);

    // Reset during ld1.
    do_fetch(op_load, 3'b010, 7'd0);
    next_cycle();
    next_cycle();
    check("rstld_ld1_read", bus.mem_read, 1'b1);
    rst = 1'b0;
    next_cycle();
    check("rstld_read_dropped", bus.mem_read, 1'b0);
    check("rstld_enables", enables(), 6'b0);
    rst = 1'b1;
    #1;
    check("rstld_fetch1_mar", load_mar, 1'b1);

    // srai.
    do_fetch(op_imm, 3'b101, 7'h20);
    next_cycle();
    check("srai_aluop", aluop, alu_sra);
    next_cycle();

    // srli.
    do_fetch(op_imm, 3'b101, 7'h00);
    next_cycle();
    check("srli_aluop", aluop, alu_srl);
    next_cycle();

    // slti.
    do_fetch(op_imm, 3'b010, 7'h00);
    next_cycle();
    check("slti_cmpmux", cmpmux_sel, cmpmux_i_imm);
    check("slti_regfilemux", regfilemux_sel, regfilemux_br_en);
    next_cycle();

    // sub.
    do_fetch(op_reg, 3'b000, 7'h20);
    next_cycle();
    check("sub_aluop", aluop, alu_sub);
    check("sub_alumux2", alumux2_sel, alumux2_rs2_out);
    next_cycle();

    // jalr.
    do_fetch(op_jalr, 3'b000, 7'h00);
    next_cycle();
    check("jalr_pcmux", pcmux_sel, pcmux_alu_mod2);
    check("jalr_regfilemux", regfilemux_sel, regfilemux_pc_plus4);
    check("jalr_load", {load_pc, load_regfile}, 2'b11);
    next_cycle();

    // Unrecognised opcode.
    do_fetch(7'h7F, 3'b000, 7'h00);
    check("bad_decode_enables", enables(), 6'b0);
    next_cycle();
    check("bad_fetch1_enables", enables(), 6'b010000);
    check("bad_fetch1_read", bus.mem_read, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
